// File: rtl/rs_dispatch_pkg.sv
// Shared definitions for the reservation-station dispatch stage: field widths,
// the packed instruction payload, its bit offsets and register-access encodings.
package rs_dispatch_pkg;

    localparam int NUM_RS                  = 4;
    localparam int QUEUE_DEPTH_BITS        = 2;

    localparam int ADDRESS_WIDTH           = 64;
    localparam int INST_COUNTER_WIDTH      = 64;
    localparam int INST_MIN_ID_WIDTH       = 5;
    localparam int OPCODE_SIZE             = 12;
    localparam int PID_SIZE                = 20;
    localparam int TID_SIZE                = 16;
    localparam int REG_ACCESS_PATTERN_SIZE = 2;
    localparam int FUNC_UNIT_CODE_SIZE     = 3;
    localparam int INST_FORMAT_WIDTH       = 25;
    localparam int BODY_WIDTH              = 84;

    localparam int PAYLOAD_WIDTH           = 306;

    // Bit offsets (LSB position) of each field inside the packed payload.
    localparam int OFF_BODY          = 0;
    localparam int OFF_OP4_IS_REG    = 84;
    localparam int OFF_OP3_IS_REG    = 85;
    localparam int OFF_OP2_IS_REG    = 86;
    localparam int OFF_OP1_IS_REG    = 87;
    localparam int OFF_OP4_RW        = 88;
    localparam int OFF_OP3_RW        = 90;
    localparam int OFF_OP2_RW        = 92;
    localparam int OFF_OP1_RW        = 94;
    localparam int OFF_TID           = 96;
    localparam int OFF_PID           = 112;
    localparam int OFF_IS_64BIT      = 132;
    localparam int OFF_MIN_ID        = 133;
    localparam int OFF_MAJ_ID        = 138;
    localparam int OFF_FUNC_UNIT     = 202;
    localparam int OFF_ADDRESS       = 205;
    localparam int OFF_OPCODE        = 269;
    localparam int OFF_INST_FORMAT   = 281;

    // Operand register access pattern carried in the opNrw fields.
    typedef enum logic [REG_ACCESS_PATTERN_SIZE-1:0] {
        REG_NONE       = 2'b00,
        REG_READ       = 2'b01,
        REG_WRITE      = 2'b10,
        REG_READ_WRITE = 2'b11
    } reg_access_e;

    // Field order matches the offsets above (first member is the MSB end).
    typedef struct packed {
        logic [INST_FORMAT_WIDTH-1:0]       inst_format;
        logic [OPCODE_SIZE-1:0]             opcode;
        logic [ADDRESS_WIDTH-1:0]           address;
        logic [FUNC_UNIT_CODE_SIZE-1:0]     func_unit_type;
        logic [INST_COUNTER_WIDTH-1:0]      maj_id;
        logic [INST_MIN_ID_WIDTH-1:0]       min_id;
        logic                               is_64bit;
        logic [PID_SIZE-1:0]                pid;
        logic [TID_SIZE-1:0]                tid;
        logic [REG_ACCESS_PATTERN_SIZE-1:0] op1_rw;
        logic [REG_ACCESS_PATTERN_SIZE-1:0] op2_rw;
        logic [REG_ACCESS_PATTERN_SIZE-1:0] op3_rw;
        logic [REG_ACCESS_PATTERN_SIZE-1:0] op4_rw;
        logic                               op1_is_reg;
        logic                               op2_is_reg;
        logic                               op3_is_reg;
        logic                               op4_is_reg;
        logic [BODY_WIDTH-1:0]              body;
    } payload_t;

endpackage

// File: rtl/rs_dispatch_queue.sv
// Small in-order FIFO with combinational head-data port, flush and occupancy count.
module dispatch_queue #(
    parameter int WIDTH      = 306,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      push_data,
    output logic [WIDTH-1:0]      head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    localparam int                  DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = DEPTH[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] CNT_ONE   = 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] head_q, head_d;
    logic [DEPTH_BITS-1:0] tail_q, tail_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    // Pointer and count update; flush wins over any push/pop in the same cycle.
    always_comb begin
        full    = (count_q == DEPTH_CNT);
        empty   = (count_q == '0);
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_ONE;
            if (do_pop)  head_d = head_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_q] <= push_data;
    end

    assign head_data = mem[head_q];
    assign count     = count_q;

endmodule

// File: rtl/rs_dispatch.sv
// In-order dispatch stage: buffers decoded instructions and strobes them into
// the reservation station chosen by funcUnitType, stalling on that station's full flag.
module rs_dispatch
    import rs_dispatch_pkg::*;
#(
    parameter int NUM_RS_P           = NUM_RS,
    parameter int QUEUE_DEPTH_BITS_P = QUEUE_DEPTH_BITS
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [INST_FORMAT_WIDTH-1:0]       instFormat_i,
    input  logic [OPCODE_SIZE-1:0]             opcode_i,
    input  logic [ADDRESS_WIDTH-1:0]           address_i,
    input  logic [FUNC_UNIT_CODE_SIZE-1:0]     funcUnitType_i,
    input  logic [INST_COUNTER_WIDTH-1:0]      majID_i,
    input  logic [INST_MIN_ID_WIDTH-1:0]       minID_i,
    input  logic                               is64Bit_i,
    input  logic [PID_SIZE-1:0]                pid_i,
    input  logic [TID_SIZE-1:0]                tid_i,
    input  logic [REG_ACCESS_PATTERN_SIZE-1:0] op1rw_i,
    input  logic [REG_ACCESS_PATTERN_SIZE-1:0] op2rw_i,
    input  logic [REG_ACCESS_PATTERN_SIZE-1:0] op3rw_i,
    input  logic [REG_ACCESS_PATTERN_SIZE-1:0] op4rw_i,
    input  logic                               op1IsReg_i,
    input  logic                               op2IsReg_i,
    input  logic                               op3IsReg_i,
    input  logic                               op4IsReg_i,
    input  logic [BODY_WIDTH-1:0]              body_i,
    input  logic [NUM_RS_P-1:0]                rsFull_i,
    output logic                               stall_o,
    output logic [NUM_RS_P-1:0]                rsEnable_o,
    output logic [INST_FORMAT_WIDTH-1:0]       instFormat_o,
    output logic [OPCODE_SIZE-1:0]             opcode_o,
    output logic [ADDRESS_WIDTH-1:0]           address_o,
    output logic [FUNC_UNIT_CODE_SIZE-1:0]     funcUnitType_o,
    output logic [INST_COUNTER_WIDTH-1:0]      majID_o,
    output logic [INST_MIN_ID_WIDTH-1:0]       minID_o,
    output logic                               is64Bit_o,
    output logic [PID_SIZE-1:0]                pid_o,
    output logic [TID_SIZE-1:0]                tid_o,
    output logic [REG_ACCESS_PATTERN_SIZE-1:0] op1rw_o,
    output logic [REG_ACCESS_PATTERN_SIZE-1:0] op2rw_o,
    output logic [REG_ACCESS_PATTERN_SIZE-1:0] op3rw_o,
    output logic [REG_ACCESS_PATTERN_SIZE-1:0] op4rw_o,
    output logic                               op1IsReg_o,
    output logic                               op2IsReg_o,
    output logic                               op3IsReg_o,
    output logic                               op4IsReg_o,
    output logic [BODY_WIDTH-1:0]              body_o,
    output logic                               illegalFU_o
);

    localparam int                          DEPTH_INT = 1 << QUEUE_DEPTH_BITS_P;
    localparam logic [QUEUE_DEPTH_BITS_P:0] DEPTH_CNT = DEPTH_INT[QUEUE_DEPTH_BITS_P:0];

    payload_t                      in_pl;
    payload_t                      head_pl;
    payload_t                      payload_q, payload_d;
    logic [NUM_RS_P-1:0]           rs_enable_q, rs_enable_d;
    logic                          illegal_fu_q, illegal_fu_d;
    logic [NUM_RS_P-1:0]           station_hit;
    logic                          queue_full;
    logic                          queue_empty;
    logic [QUEUE_DEPTH_BITS_P:0]   queue_count;
    logic                          queue_push;
    logic                          queue_pop;
    logic                          do_dispatch;
    logic                          do_drop;

    assign in_pl = '{
        inst_format:    instFormat_i,
        opcode:         opcode_i,
        address:        address_i,
        func_unit_type: funcUnitType_i,
        maj_id:         majID_i,
        min_id:         minID_i,
        is_64bit:       is64Bit_i,
        pid:            pid_i,
        tid:            tid_i,
        op1_rw:         op1rw_i,
        op2_rw:         op2rw_i,
        op3_rw:         op3rw_i,
        op4_rw:         op4rw_i,
        op1_is_reg:     op1IsReg_i,
        op2_is_reg:     op2IsReg_i,
        op3_is_reg:     op3IsReg_i,
        op4_is_reg:     op4IsReg_i,
        body:           body_i
    };

    dispatch_queue #(
        .WIDTH      (PAYLOAD_WIDTH),
        .DEPTH_BITS (QUEUE_DEPTH_BITS_P)
    ) u_queue (
        .clk       (clock_i),
        .rst       (reset_i),
        .flush     (flush_i),
        .push      (queue_push),
        .pop       (queue_pop),
        .push_data (in_pl),
        .head_data (head_pl),
        .full      (queue_full),
        .empty     (queue_empty),
        .count     (queue_count)
    );

    // One-hot decode of the head's target station; all-zero means an illegal code.
    for (genvar gi = 0; gi < NUM_RS_P; gi++) begin : g_station_hit
        assign station_hit[gi] = (head_pl.func_unit_type == FUNC_UNIT_CODE_SIZE'(gi));
    end

    // Routing decision: dispatch to a free station, hold on a full one, drop illegal codes.
    always_comb begin
        do_dispatch  = !queue_empty && !flush_i && (|(station_hit & ~rsFull_i));
        do_drop      = !queue_empty && !flush_i && !(|station_hit);
        queue_pop    = do_dispatch || do_drop;
        queue_push   = enable_i && !queue_full && !flush_i;
        rs_enable_d  = do_dispatch ? station_hit : '0;
        illegal_fu_d = do_drop;
        payload_d    = do_dispatch ? head_pl : payload_q;
    end

    // Output registers; asynchronous reset clears strobes and payload immediately.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rs_enable_q  <= '0;
            illegal_fu_q <= 1'b0;
            payload_q    <= '0;
        end else begin
            rs_enable_q  <= rs_enable_d;
            illegal_fu_q <= illegal_fu_d;
            payload_q    <= payload_d;
        end
    end

    // Stall is decoded from the registered occupancy only, so it never depends on
    // this cycle's pop.
    assign stall_o        = (queue_count == DEPTH_CNT);
    assign rsEnable_o     = rs_enable_q;
    assign illegalFU_o    = illegal_fu_q;
    assign instFormat_o   = payload_q.inst_format;
    assign opcode_o       = payload_q.opcode;
    assign address_o      = payload_q.address;
    assign funcUnitType_o = payload_q.func_unit_type;
    assign majID_o        = payload_q.maj_id;
    assign minID_o        = payload_q.min_id;
    assign is64Bit_o      = payload_q.is_64bit;
    assign pid_o          = payload_q.pid;
    assign tid_o          = payload_q.tid;
    assign op1rw_o        = payload_q.op1_rw;
    assign op2rw_o        = payload_q.op2_rw;
    assign op3rw_o        = payload_q.op3_rw;
    assign op4rw_o        = payload_q.op4_rw;
    assign op1IsReg_o     = payload_q.op1_is_reg;
    assign op2IsReg_o     = payload_q.op2_is_reg;
    assign op3IsReg_o     = payload_q.op3_is_reg;
    assign op4IsReg_o     = payload_q.op4_is_reg;
    assign body_o         = payload_q.body;

endmodule

// File: tb/tb_rs_dispatch.sv
// Self-checking bench for rs_dispatch: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_rs_dispatch;

    typedef struct packed {
        logic [24:0] inst_format;
        logic [11:0] opcode;
        logic [63:0] address;
        logic [2:0]  fu;
        logic [63:0] maj_id;
        logic [4:0]  min_id;
        logic        is64;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [1:0]  op1rw, op2rw, op3rw, op4rw;
        logic        op1_is_reg, op2_is_reg, op3_is_reg, op4_is_reg;
        logic [83:0] body;
    } pl_t;

    logic        clock_i;
    logic        reset_i;
    logic        flush_i;
    logic        enable_i;
    logic [3:0]  rsFull_i;
    pl_t         in_pl;

    logic        stall_o;
    logic [3:0]  rsEnable_o;
    logic        illegalFU_o;
    logic [24:0] instFormat_o;
    logic [11:0] opcode_o;
    logic [63:0] address_o;
    logic [2:0]  funcUnitType_o;
    logic [63:0] majID_o;
    logic [4:0]  minID_o;
    logic        is64Bit_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [1:0]  op1rw_o, op2rw_o, op3rw_o, op4rw_o;
    logic        op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
    logic [83:0] body_o;
    pl_t         dut_pl;

    int          checks   = 0;
    int          failures = 0;

    // Behavioural model state: the queue contents and the expected registered outputs.
    pl_t         model_q[$];
    logic [3:0]  exp_en;
    logic        exp_ill;
    logic        exp_stall;
    pl_t         exp_pl;

    rs_dispatch dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .enable_i       (enable_i),
        .instFormat_i   (in_pl.inst_format),
        .opcode_i       (in_pl.opcode),
        .address_i      (in_pl.address),
        .funcUnitType_i (in_pl.fu),
        .majID_i        (in_pl.maj_id),
        .minID_i        (in_pl.min_id),
        .is64Bit_i      (in_pl.is64),
        .pid_i          (in_pl.pid),
        .tid_i          (in_pl.tid),
        .op1rw_i        (in_pl.op1rw),
        .op2rw_i        (in_pl.op2rw),
        .op3rw_i        (in_pl.op3rw),
        .op4rw_i        (in_pl.op4rw),
        .op1IsReg_i     (in_pl.op1_is_reg),
        .op2IsReg_i     (in_pl.op2_is_reg),
        .op3IsReg_i     (in_pl.op3_is_reg),
        .op4IsReg_i     (in_pl.op4_is_reg),
        .body_i         (in_pl.body),
        .rsFull_i       (rsFull_i),
        .stall_o        (stall_o),
        .rsEnable_o     (rsEnable_o),
        .instFormat_o   (instFormat_o),
        .opcode_o       (opcode_o),
        .address_o      (address_o),
        .funcUnitType_o (funcUnitType_o),
        .majID_o        (majID_o),
        .minID_o        (minID_o),
        .is64Bit_o      (is64Bit_o),
        .pid_o          (pid_o),
        .tid_o          (tid_o),
        .op1rw_o        (op1rw_o),
        .op2rw_o        (op2rw_o),
        .op3rw_o        (op3rw_o),
        .op4rw_o        (op4rw_o),
        .op1IsReg_o     (op1IsReg_o),
        .op2IsReg_o     (op2IsReg_o),
        .op3IsReg_o     (op3IsReg_o),
        .op4IsReg_o     (op4IsReg_o),
        .body_o         (body_o),
        .illegalFU_o    (illegalFU_o)
    );

    assign dut_pl = {instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
                     is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
                     op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o};

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    function automatic pl_t rand_pl(input logic [2:0] fu);
        pl_t         p;
        logic [95:0] b;
        p.inst_format = 25'($urandom);
        p.opcode      = 12'($urandom);
        p.address     = {$urandom, $urandom};
        p.fu          = fu;
        p.maj_id      = {$urandom, $urandom};
        p.min_id      = 5'($urandom);
        p.is64        = 1'($urandom);
        p.pid         = 20'($urandom);
        p.tid         = 16'($urandom);
        p.op1rw       = 2'($urandom);
        p.op2rw       = 2'($urandom);
        p.op3rw       = 2'($urandom);
        p.op4rw       = 2'($urandom);
        p.op1_is_reg  = 1'($urandom);
        p.op2_is_reg  = 1'($urandom);
        p.op3_is_reg  = 1'($urandom);
        p.op4_is_reg  = 1'($urandom);
        b             = {$urandom, $urandom, $urandom};
        p.body        = b[83:0];
        return p;
    endfunction

    // Drive one cycle's inputs, advance the model across the coming edge, then
    // return on the following falling edge where outputs are sampled.
    task automatic cycle(input logic en, input logic fl, input logic [3:0] full, input pl_t p);
        bit  was_full;
        pl_t h;
        enable_i = en;
        flush_i  = fl;
        rsFull_i = full;
        in_pl    = p;
        was_full = (model_q.size() == 4);
        exp_en   = 4'b0000;
        exp_ill  = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0) begin
                h = model_q[0];
                if (h.fu < 3'd4) begin
                    if (!full[h.fu[1:0]]) begin
                        exp_en = 4'b0001 << h.fu[1:0];
                        exp_pl = h;
                        void'(model_q.pop_front());
                    end
                end else begin
                    exp_ill = 1'b1;
                    void'(model_q.pop_front());
                end
            end
            if (en && !was_full) model_q.push_back(p);
        end
        exp_stall = (model_q.size() == 4);
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic apply_reset();
        reset_i  = 1'b1;
        enable_i = 1'b0;
        flush_i  = 1'b0;
        rsFull_i = 4'b0000;
        in_pl    = '0;
        @(posedge clock_i);
        @(posedge clock_i);
        @(negedge clock_i);
        reset_i   = 1'b0;
        model_q.delete();
        exp_en    = 4'b0000;
        exp_ill   = 1'b0;
        exp_stall = 1'b0;
        exp_pl    = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (rsEnable_o !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rs_enable got=%b want=%b", rsEnable_o, 4'b0000);
        end
        checks++;
        if (illegalFU_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_illegal got=%b want=0", illegalFU_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b want=0", stall_o);
        end
        checks++;
        if (dut_pl !== pl_t'(0)) begin
            failures++;
            $display("FAIL reset_payload got=%h want=0", dut_pl);
        end
    endtask

    task automatic test_single_dispatch();
        pl_t p;
        p        = rand_pl(3'd2);
        p.maj_id = 64'h10;
        cycle(1'b1, 1'b0, 4'b0000, p);
        checks++;
        if (rsEnable_o !== 4'b0000) begin
            failures++;
            $display("FAIL single_no_bypass got=%b want=0000", rsEnable_o);
        end
        cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
        checks++;
        if (rsEnable_o !== 4'b0100) begin
            failures++;
            $display("FAIL single_strobe got=%b want=0100", rsEnable_o);
        end
        checks++;
        if (majID_o !== 64'h10) begin
            failures++;
            $display("FAIL single_majid got=%h want=10", majID_o);
        end
        checks++;
        if (dut_pl !== p) begin
            failures++;
            $display("FAIL single_payload got=%h want=%h", dut_pl, p);
        end
        cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd1));
        checks++;
        if (rsEnable_o !== 4'b0000) begin
            failures++;
            $display("FAIL single_one_cycle got=%b want=0000", rsEnable_o);
        end
    endtask

    task automatic test_head_of_line();
        logic [2:0] fus  [3] = '{3'd1, 3'd0, 3'd3};
        logic [3:0] want [3] = '{4'b0010, 4'b0001, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 4'b0010, rand_pl(fus[i]));
            checks++;
            if (rsEnable_o !== 4'b0000) begin
                failures++;
                $display("FAIL hol_blocked_%0d got=%b want=0000", i, rsEnable_o);
            end
        end
        cycle(1'b0, 1'b0, 4'b0010, rand_pl(3'd0));
        checks++;
        if (rsEnable_o !== 4'b0000) begin
            failures++;
            $display("FAIL hol_still_blocked got=%b want=0000", rsEnable_o);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
            checks++;
            if (rsEnable_o !== want[i]) begin
                failures++;
                $display("FAIL hol_order_%0d got=%b want=%b", i, rsEnable_o, want[i]);
            end
            checks++;
            if (dut_pl !== exp_pl) begin
                failures++;
                $display("FAIL hol_payload_%0d got=%h want=%h", i, dut_pl, exp_pl);
            end
        end
    endtask

    task automatic test_stall();
        pl_t p;
        pl_t p5;
        for (int i = 0; i < 4; i++) begin
            p        = rand_pl(3'd0);
            p.maj_id = 64'(i + 1);
            cycle(1'b1, 1'b0, 4'b1111, p);
            checks++;
            if (stall_o !== (i == 3)) begin
                failures++;
                $display("FAIL stall_after_push_%0d got=%b want=%b", i, stall_o, (i == 3));
            end
        end
        p5        = rand_pl(3'd0);
        p5.maj_id = 64'd5;
        // Decode holds p5 while stalled; the pop at this edge must not admit it.
        cycle(1'b1, 1'b0, 4'b1110, p5);
        checks++;
        if (rsEnable_o !== 4'b0001 || majID_o !== 64'd1) begin
            failures++;
            $display("FAIL stall_first_pop got=%b/%0d want=0001/1", rsEnable_o, majID_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got=%b want=0", stall_o);
        end
        cycle(1'b1, 1'b0, 4'b0000, p5);
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (rsEnable_o !== 4'b0001 || majID_o !== 64'(i)) begin
                failures++;
                $display("FAIL stall_drain_%0d got=%b/%0d want=0001/%0d", i, rsEnable_o, majID_o, i);
            end
            cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
        end
        checks++;
        if (rsEnable_o !== 4'b0000) begin
            failures++;
            $display("FAIL stall_drained got=%b want=0000", rsEnable_o);
        end
    endtask

    task automatic test_illegal_fu();
        cycle(1'b1, 1'b0, 4'b0000, rand_pl(3'd6));
        cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
        checks++;
        if (illegalFU_o !== 1'b1 || rsEnable_o !== 4'b0000) begin
            failures++;
            $display("FAIL illegal_pulse got=%b/%b want=1/0000", illegalFU_o, rsEnable_o);
        end
        cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
        checks++;
        if (illegalFU_o !== 1'b0) begin
            failures++;
            $display("FAIL illegal_one_cycle got=%b want=0", illegalFU_o);
        end
        // Occupancy must be back to zero: the queue takes exactly four more entries.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 4'b1111, rand_pl(3'd1));
            checks++;
            if (stall_o !== (i == 3)) begin
                failures++;
                $display("FAIL illegal_count_%0d got=%b want=%b", i, stall_o, (i == 3));
            end
        end
        cycle(1'b0, 1'b1, 4'b0000, rand_pl(3'd0));
    endtask

    task automatic test_flush();
        pl_t p;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'b1111, rand_pl(3'(i)));
        cycle(1'b1, 1'b1, 4'b1111, rand_pl(3'd3));
        checks++;
        if (stall_o !== 1'b0 || rsEnable_o !== 4'b0000) begin
            failures++;
            $display("FAIL flush_clear got=%b/%b want=0/0000", stall_o, rsEnable_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
            checks++;
            if (rsEnable_o !== 4'b0000 || illegalFU_o !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_strobe_%0d got=%b/%b want=0000/0", i, rsEnable_o, illegalFU_o);
            end
        end
        p = rand_pl(3'd2);
        cycle(1'b1, 1'b0, 4'b0000, p);
        cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
        checks++;
        if (rsEnable_o !== 4'b0100 || dut_pl !== p) begin
            failures++;
            $display("FAIL flush_resume got=%b/%h want=0100/%h", rsEnable_o, dut_pl, p);
        end
    endtask

    task automatic test_async_reset();
        pl_t p;
        p        = rand_pl(3'd1);
        p.maj_id = 64'hABCD;
        cycle(1'b1, 1'b0, 4'b0000, p);
        cycle(1'b0, 1'b0, 4'b0000, rand_pl(3'd0));
        checks++;
        if (rsEnable_o !== 4'b0010) begin
            failures++;
            $display("FAIL areset_setup got=%b want=0010", rsEnable_o);
        end
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if (rsEnable_o !== 4'b0000 || majID_o !== 64'h0) begin
            failures++;
            $display("FAIL areset_immediate got=%b/%h want=0000/0", rsEnable_o, majID_o);
        end
        checks++;
        if (dut_pl !== pl_t'(0) || illegalFU_o !== 1'b0) begin
            failures++;
            $display("FAIL areset_payload got=%h/%b want=0/0", dut_pl, illegalFU_o);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic       en;
        logic       fl;
        logic [3:0] full;
        logic [2:0] fu;
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 39) == 0);
            full = 4'($urandom) & 4'($urandom);
            fu   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            cycle(en, fl, full, rand_pl(fu));
            checks++;
            if (rsEnable_o !== exp_en || illegalFU_o !== exp_ill || stall_o !== exp_stall) begin
                failures++;
                $display("FAIL random_ctrl_%0d got=%b/%b/%b want=%b/%b/%b", n,
                         rsEnable_o, illegalFU_o, stall_o, exp_en, exp_ill, exp_stall);
            end
            checks++;
            if (dut_pl !== exp_pl) begin
                failures++;
                $display("FAIL random_payload_%0d got=%h want=%h", n, dut_pl, exp_pl);
            end
        end
    endtask

    initial begin
        reset_i  = 1'b1;
        enable_i = 1'b0;
        flush_i  = 1'b0;
        rsFull_i = 4'b0000;
        in_pl    = '0;
        test_reset();
        test_single_dispatch();
        test_head_of_line();
        test_stall();
        test_illegal_fu();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_dispatch.md
# rs_dispatch

In-order dispatch stage feeding the reservation stations. It accepts decoded instructions from the decode stage and buffers them in a small FIFO. It routes each instruction to the reservation station selected by its functional-unit code, presenting it on a shared payload bus with a one-hot per-station enable, and honours each station's full flag. It is the transmitter side of the reservation-station allocate interface.

## Interface
- numRS, 4: number of reservation stations driven; funcUnitType value k targets station k
- queueDepthBits, 2: FIFO depth = 2**queueDepthBits (4 entries)
- addressWidth 64, instructionCounterWidth 64, instMinIdWidth 5, opcodeSize 12, PidSize 20, TidSize 16, regAccessPatternSize 2, funcUnitCodeSize 3: field widths, same meaning as in the reservation station
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous queue clear
- enable_i  in  1  decode presents a valid instruction
- instFormat_i  in  25; opcode_i  in  opcodeSize; address_i  in  addressWidth; funcUnitType_i  in  funcUnitCodeSize; majID_i  in  instructionCounterWidth; minID_i  in  instMinIdWidth; is64Bit_i  in  1; pid_i  in  PidSize; tid_i  in  TidSize
- op1rw_i..op4rw_i  in  2 each; op1IsReg_i..op4IsReg_i  in  1 each; body_i  in  84: instruction payload
- rsFull_i  in  numRS  per-station full flag (the station's isFull_o)
- stall_o  out  1  decode must hold its instruction
- rsEnable_o  out  numRS  one-hot allocate strobe
- all payload fields mirrored as outputs: instFormat_o … body_o, same widths; shared by all stations
- illegalFU_o  out  1  one-cycle pulse when an instruction with funcUnitType ≥ numRS is discarded

## Operation
- Push: on a rising edge with enable_i=1, stall_o=0 and flush_i=0, the 306-bit payload is written at the tail and count increments.
- stall_o = (count == 2**queueDepthBits). It is decoded from registered count only. When the queue is full no push occurs, even if a pop happens in the same cycle.
- Pop/dispatch: on each edge with count>0, flush_i=0 and head target k:
  - k < numRS and rsFull_i[k]=0: drive the payload registers from the head, set rsEnable_o = (1<<k), and pop.
  - k < numRS and rsFull_i[k]=1: hold the head. rsEnable_o=0 and payload outputs are unchanged. The queue is strictly in order (head-of-line blocking).
  - k ≥ numRS: pop without dispatch, set rsEnable_o=0, and pulse illegalFU_o=1.
- Simultaneous push and pop with count between 1 and depth-1: count is unchanged, and both pointers advance modulo depth.
- Empty queue: an instruction pushed at edge N is dispatched no earlier than edge N+1 (no bypass).
- flush_i=1: head, tail and count are cleared to 0, rsEnable_o=0 and illegalFU_o=0. An incoming instruction in the same cycle is dropped. Flush takes priority over push and pop.
- Reset (asynchronous, any time, including mid-dispatch): pointers, count, rsEnable_o, illegalFU_o and all payload outputs go to 0, so stall_o=0. Queue storage need not be cleared.

## Timing
- Latency from accept to rsEnable_o is 1 cycle when the queue is empty and the target is not full.
- Throughput is 1 instruction/cycle sustained when targets are not full.
- rsEnable_o and illegalFU_o are registered and high for exactly one cycle per instruction.
- rsFull_i is sampled at the same edge that would dispatch. The station must raise isFull_o while it can accept no more entries.
- stall_o changes only after an edge. Decode samples it combinationally in the same cycle.

## Structure
- Shared package:
  - funcUnitCodeSize and regAccessPatternSize
  - payload width constant (306)
  - payload field offsets
  - regRead/regWrite encodings
- Sub-module dispatch_queue: a parameterised synchronous FIFO with push, pop, flush, full, empty, count and a head-data port.
- rs_dispatch holds the routing decision, the one-hot decode and the output registers.

## Test plan
- Reset then push one instruction, funcUnitType=2, majID=0x10, all rsFull_i=0 → one cycle later rsEnable_o=4'b0100, majID_o=0x10; next cycle rsEnable_o=0.
- rsFull_i[1]=1, push types 1,0,3 → nothing dispatched; after rsFull_i[1] drops, three consecutive strobes 0010, 0001, 1000 in order.
- Hold rsFull_i=4'b1111, push 5 instructions → stall_o=1 after the 4th accept; the 5th is held by decode and accepted only after the first pop.
- Push funcUnitType=6 → illegalFU_o pulses once, rsEnable_o stays 0, and count returns to 0.
- Queue with 3 entries, flush_i=1 with enable_i=1 → next cycle count=0, stall_o=0, no strobes, and the incoming instruction is never dispatched.
- Assert reset_i between clock edges while rsEnable_o=1 → rsEnable_o and majID_o go to 0 immediately, before the next clock edge.
